inv_rnd_key_gen: RTL and testbench
==================================

Name: inv_rnd_key_gen

Overview:
- Iterative AES-128 inverse key schedule for the decryption engine.
- Starts from the round-10 key, which key expansion produces last, and walks backward.
- Emits round keys 10, 9, ..., 0 in order, one per consumer handshake, so the decryption datapath can apply round keys in reverse without storing all 11 expanded keys.

Parameters:
- none (AES-128 fixed: 128-bit key, 10 rounds)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin a walk from lastKey (accepted only in IDLE)
- lastKey  in  [0:127]  round-10 key; sampled only on start acceptance
- keyReady  in  1  consumer accepts keyOut this cycle
- keyOut  out  [0:127]  current round key, big-endian bit order (word0 = [0:31])
- rndIdx  out  [0:3]  round number of keyOut (10 down to 0)
- keyValid  out  1  keyOut/rndIdx valid; held until keyReady
- busy  out  1  walk in progress (not IDLE)
- done  out  1  one-cycle pulse after round-0 key handshake

Behaviour:
- Reset (rst=0, async): keyOut=0, rndIdx=0, keyValid=0, busy=0, done=0, FSM=IDLE, internal key register=0.
- FSM states: IDLE, OUT, SUB, COMB.
- IDLE:
  - start=1 -> cur<=lastKey, rnd<=10, go to OUT.
  - Otherwise stay in IDLE.
- OUT:
  - keyValid=1, keyOut=cur, rndIdx=rnd. keyOut/rndIdx must not change while keyValid=1 and keyReady=0.
  - keyValid & keyReady & rnd==0 -> done=1 next cycle, go to IDLE.
  - keyValid & keyReady & rnd!=0 -> go to SUB.
- SUB:
  - p3=cur[96:127]^cur[64:95], p2=cur[64:95]^cur[32:63], p1=cur[32:63]^cur[0:31].
  - RotWord(p3) = left byte rotate by 1, driven into four instances of the team's registered byte S-box (1-cycle latency; S-box reset tied to ~rst).
  - Next state COMB.
- COMB:
  - p0 = cur[0:31] ^ subOut ^ {rcon(rnd), 24'b0}.
  - cur<={p0,p1,p2,p3}, rnd<=rnd-1, go to OUT.
- rcon(rnd) for rnd 1..10 = 01,02,04,08,10,20,40,80,1B,36; any other index = 00. This never occurs in normal operation.
- Latency:
  - start accepted -> keyValid high the next cycle (round 10 = lastKey unchanged).
  - Handshake in OUT -> next keyValid 3 cycles later (keyValid low during SUB and COMB).
  - With keyReady tied high: 11 keys over 31 cycles; done asserts in the cycle after the rnd=0 handshake.
- busy=1 in OUT/SUB/COMB; busy=0 in IDLE, including the done cycle.
- start while busy: ignored, with no effect on cur/rnd.
- start in the same cycle as done: accepted, because the FSM is IDLE in that cycle.
- Reset mid-walk: immediate return to reset values; no done pulse; a new start is required.
- keyOut holds the last value in IDLE after a walk (round-0 key), with keyValid=0.

Test Plan:
- FIPS-197 A.1: lastKey=d014f9a8c9ee2589e13f0cc8b6630ca6, keyReady=1, start pulse:
  - rndIdx 10 keyOut=lastKey.
  - rndIdx 9 = ac7766f319fadc2128d12941575c006e.
  - rndIdx 1 = a0fafe1788542cb123a339392a6c7605.
  - rndIdx 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done one cycle after the rndIdx 0 handshake; 31 cycles total.
- Backpressure: keyReady=0 for 5 cycles at rndIdx 9 -> keyValid, keyOut and rndIdx stable; sequence resumes 3 cycles after keyReady=1.
- Start while busy: second start with a different lastKey mid-walk -> ignored; all 11 keys match the first lastKey.
- Async reset: assert rst=0 mid-cycle while in COMB at round 5 -> all outputs 0 immediately, IDLE; a new start with the A.1 key reproduces the full sequence.
- Back-to-back: start asserted in the done cycle -> new walk begins; the next cycle shows keyValid=1, rndIdx=10.
- Round trip: feed round 10 from the genRndKey chain for random key K (100 seeds) -> rndIdx 0 output equals K every time.

Source files
------------

// File: rtl/inv_rnd_key_gen.sv
// inv_rnd_key_gen: iterative AES-128 inverse key schedule emitting round keys 10 down to 0
module aes_sbox_reg (
    input  logic       clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    logic [7:0] r_byte;
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s, r;
        s = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction
    // substituted byte appears one cycle after its input (multiplicative inverse as a^254, then affine map)
    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) r_byte <= 8'h00;
        else       r_byte <= sbox(i_byte);
    assign o_byte = r_byte;
endmodule

module inv_rnd_key_gen (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] lastKey,
    input  logic         keyReady,
    output logic [0:127] keyOut,
    output logic [0:3]   rndIdx,
    output logic         keyValid,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, OUT, SUB, COMB} state_t;
    state_t       r_state, w_next;
    logic [0:127] r_cur;
    logic [0:3]   r_rnd;
    logic         r_done;
    logic [0:31]  w_p0, w_p1, w_p2, w_p3, w_rot, w_sub;
    logic         w_hs;
    function automatic logic [0:7] rcon(input logic [0:3] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction
    assign w_p3 = r_cur[96:127] ^ r_cur[64:95];
    assign w_p2 = r_cur[64:95] ^ r_cur[32:63];
    assign w_p1 = r_cur[32:63] ^ r_cur[0:31];
    assign w_rot = {w_p3[8:31], w_p3[0:7]};
    assign w_p0 = r_cur[0:31] ^ w_sub ^ {rcon(r_rnd), 24'h000000};
    assign w_hs = (r_state == OUT) && keyReady;
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox_reg u_sbox (
            .clk    (clk),
            .i_rst  (~rst),
            .i_byte (w_rot[8*i +: 8]),
            .o_byte (w_sub[8*i +: 8])
        );
    end
    // next state: OUT waits for the handshake, SUB waits out the S-box latency, COMB commits the previous key
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? OUT : IDLE;
            OUT:     w_next = keyReady ? ((r_rnd == 4'd0) ? IDLE : SUB) : OUT;
            SUB:     w_next = COMB;
            COMB:    w_next = OUT;
            default: w_next = IDLE;
        endcase
    end
    // state, working key, round counter and done pulse
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_rnd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_hs && (r_rnd == 4'd0);
            if (r_state == IDLE && start) begin
                r_cur <= lastKey;
                r_rnd <= 4'd10;
            end else if (r_state == COMB) begin
                r_cur <= {w_p0, w_p1, w_p2, w_p3};
                r_rnd <= r_rnd - 4'd1;
            end
        end
    assign keyOut   = r_cur;
    assign rndIdx   = r_rnd;
    assign keyValid = (r_state == OUT);
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
endmodule

// File: tb/tb_inv_rnd_key_gen.sv
// tb_inv_rnd_key_gen: directed vectors and round-trip checks for the inverse key schedule
module tb_inv_rnd_key_gen;
    logic         clk = 1'b0, rst = 1'b0, start = 1'b0, keyReady = 1'b1;
    logic [0:127] lastKey = '0, keyOut;
    logic [0:3]   rndIdx;
    logic         keyValid, busy, done;
    int           n_cmp = 0, n_err = 0;
    typedef struct { logic [3:0] rnd; logic [127:0] key; } vec_t;
    vec_t         tv[11];
    logic [127:0] got[11];
    logic [7:0]   sbt[256];
    int           exp_r, ord_bad, nb;
    bit           inj_en = 0;
    int           inj_at = 0;
    logic [127:0] inj_key = '0;
    localparam logic [127:0] A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    always #5 clk = ~clk;

    inv_rnd_key_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .lastKey  (lastKey),
        .keyReady (keyReady),
        .keyOut   (keyOut),
        .rndIdx   (rndIdx),
        .keyValid (keyValid),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] expand10(input logic [127:0] k);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        {w0, w1, w2, w3} = k;
        for (int r = 1; r <= 10; r++) begin
            t = {sbt[w3[23:16]], sbt[w3[15:8]], sbt[w3[7:0]], sbt[w3[31:24]]} ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
        return {w0, w1, w2, w3};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_walk();
        for (int i = 0; i < 11; i++) got[i] = '0;
        exp_r = 10;
        ord_bad = 0;
    endtask

    task automatic pulse_start(input logic [127:0] key);
        @(negedge clk);
        start = 1;
        lastKey = key;
        @(negedge clk);
        start = 0;
    endtask

    // records every handshaken key until done, counting busy cycles; optional start injection mid-walk
    task automatic collect(output int nbusy);
        bit fin;
        fin = 0;
        nbusy = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            start = inj_en && (c == inj_at);
            if (start) lastKey = inj_key;
            if (busy) nbusy++;
            if (keyValid && keyReady) begin
                if (exp_r < 0 || rndIdx != exp_r[3:0]) ord_bad++;
                else got[exp_r] = keyOut;
                exp_r--;
            end
            if (done) fin = 1;
            else @(negedge clk);
        end
        start = 0;
        chk("done_seen", {127'b0, fin}, 1);
        chk("key_order", ord_bad, 0);
    endtask

    task automatic check_table(input string nm);
        for (int i = 0; i < 11; i++)
            chk($sformatf("%s_r%0d", nm, tv[i].rnd), got[tv[i].rnd], tv[i].key);
    endtask

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 0;
            for (int y = 1; y < 256; y++) if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbt[x] = b;
        end
        tv[0]  = '{4'd10, A1};
        tv[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tv[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tv[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tv[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tv[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tv[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tv[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tv[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tv[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tv[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        #12;
        chk("rst_keyOut", keyOut, 0);
        chk("rst_rndIdx", rndIdx, 0);
        chk("rst_flags", {keyValid, busy, done}, 0);
        @(negedge clk) rst = 1;

        // FIPS-197 A.1 walk with keyReady tied high
        clear_walk();
        pulse_start(A1);
        chk("a1_first_valid", {keyValid, rndIdx}, {1'b1, 4'd10});
        collect(nb);
        check_table("a1");
        chk("a1_busy_cycles", nb, 31);
        chk("a1_done_not_busy", busy, 0);

        // back-to-back: start in the done cycle
        start = 1;
        lastKey = A1;
        @(negedge clk);
        start = 0;
        chk("b2b_valid", {keyValid, rndIdx}, {1'b1, 4'd10});
        chk("b2b_key", keyOut, A1);
        clear_walk();
        collect(nb);
        chk("b2b_r0", got[0], tv[10].key);
        @(negedge clk);
        chk("idle_hold_key", keyOut, tv[10].key);
        chk("idle_hold_flags", {keyValid, busy, done}, 0);

        // start while busy is ignored
        clear_walk();
        inj_en = 1;
        inj_at = 7;
        inj_key = 128'h00112233445566778899aabbccddeeff;
        pulse_start(A1);
        collect(nb);
        inj_en = 0;
        check_table("busy_start");
        chk("busy_start_cycles", nb, 31);

        // backpressure at round 9
        clear_walk();
        pulse_start(A1);
        repeat (3) @(negedge clk);
        chk("bp_r9_valid", {keyValid, rndIdx}, {1'b1, 4'd9});
        keyReady = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_flags%0d", i), {keyValid, rndIdx}, {1'b1, 4'd9});
            chk($sformatf("bp_hold_key%0d", i), keyOut, tv[1].key);
        end
        keyReady = 1;
        @(negedge clk);
        chk("bp_gap1", keyValid, 0);
        @(negedge clk);
        chk("bp_gap2", keyValid, 0);
        @(negedge clk);
        chk("bp_resume", {keyValid, rndIdx}, {1'b1, 4'd8});
        chk("bp_resume_key", keyOut, tv[2].key);
        exp_r = 8;
        ord_bad = 0;
        collect(nb);
        chk("bp_r0", got[0], tv[10].key);

        // async reset while in COMB at round 5
        begin
            bit found;
            found = 0;
            pulse_start(A1);
            for (int c = 0; c < 100 && !found; c++) begin
                if (keyValid && rndIdx == 4'd5) found = 1;
                else @(negedge clk);
            end
            chk("rst_found_r5", {127'b0, found}, 1);
        end
        repeat (2) @(negedge clk);
        chk("rst_pre_comb", {busy, keyValid, rndIdx}, {1'b1, 1'b0, 4'd5});
        #2 rst = 0;
        #1;
        chk("arst_keyOut", keyOut, 0);
        chk("arst_rndIdx", rndIdx, 0);
        chk("arst_flags", {keyValid, busy, done}, 0);
        @(negedge clk) rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("arst_idle%0d", i), {busy, done}, 0);
        end
        clear_walk();
        pulse_start(A1);
        collect(nb);
        check_table("after_rst");

        // round trip from random keys
        for (int s = 0; s < 100; s++) begin
            logic [127:0] k, l;
            k = {$urandom, $urandom, $urandom, $urandom};
            l = expand10(k);
            clear_walk();
            pulse_start(l);
            collect(nb);
            chk($sformatf("rt%0d_r10", s), got[10], l);
            chk($sformatf("rt%0d_r0", s), got[0], k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
